// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared types, opcodes and select encodings for the multicycle RV32I controller
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
  } state_t;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALUOp/funct fields to alu_control and flags unsupported funct3
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7b5,
  output logic [2:0]  alu_control,
  output logic        illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type sub from addi, which has no sub form
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM for the shared-memory multicycle RV32I datapath
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    system_rst,
  input  logic [6:0]              op,
  input  logic [2:0]              funct3,
  input  logic                    funct7b5,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    adr_src,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic [1:0]              result_src,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [2:0]              alu_control,
  output logic [1:0]              imm_src,
  output logic                    reg_write,
  output logic                    halted,
  output logic                    instr_retired,
  output logic [RETIRE_CNT_W-1:0] retire_count
);

  state_t  state, state_next;
  alu_op_t alu_op;
  logic    alu_illegal;
  logic    pc_w, mem_w, ir_w, reg_w, retire, halt_c;

  always_ff @(posedge clk) begin
    if (system_rst) begin
      state        <= S_FETCH;
      retire_count <= '0;
    end else begin
      state <= state_next;
      if (instr_retired) retire_count <= retire_count + RETIRE_CNT_W'(1);
    end
  end

  // ALUOp depends on state alone so the illegal flag can feed next-state without a loop
  always_comb begin
    alu_op = ALUOP_ADD;
    if (state == S_EXECR || state == S_EXECI) alu_op = ALUOP_FUNCT;
    else if (state == S_BEQ)                  alu_op = ALUOP_SUB;
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control),
    .illegal     (alu_illegal)
  );

  always_comb begin
    state_next = state;
    pc_w       = 1'b0;
    mem_w      = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    retire     = 1'b0;
    halt_c     = 1'b0;
    adr_src    = ADR_PC;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (mem_ready) begin
          ir_w       = 1'b1;
          pc_w       = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        if (op == OP_LW)      state_next = S_MEMREAD;
        else if (op == OP_SW) state_next = S_MEMWRITE;
        else                  state_next = S_HALT;
      end
      S_MEMREAD: begin
        adr_src = ADR_ALUOUT;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = ADR_ALUOUT;
        mem_w   = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECR, S_EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = (state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        state_next = alu_illegal ? S_HALT : S_ALUWB;
      end
      S_ALUWB: begin
        reg_w      = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        if (funct3 == 3'b000) begin
          pc_w       = zero;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_HALT;
        end
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_w       = 1'b1;
        state_next = S_ALUWB;
      end
      S_HALT:  halt_c = 1'b1;
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  // Reset masks every side effect so a reset landing mid-instruction writes nothing
  assign pc_write      = pc_w   & ~system_rst;
  assign mem_write     = mem_w  & ~system_rst;
  assign ir_write      = ir_w   & ~system_rst;
  assign reg_write     = reg_w  & ~system_rst;
  assign instr_retired = retire & ~system_rst;
  assign halted        = halt_c & ~system_rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

  localparam int CW = 4;
  localparam logic [6:0] T_LW = 7'b0000011, T_SW = 7'b0100011, T_R = 7'b0110011;
  localparam logic [6:0] T_I = 7'b0010011, T_BEQ = 7'b1100011, T_JAL = 7'b1101111;

  logic clk = 1'b0;
  logic system_rst, funct7b5, zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, halted, instr_retired;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [CW-1:0] retire_count;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;
  int ncyc = 0;

  multicycle_controller #(.RETIRE_CNT_W(CW)) dut (
    .clk(clk), .system_rst(system_rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_write(reg_write), .halted(halted),
    .instr_retired(instr_retired), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  wire [16:0] obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                     alu_src_b, alu_control, reg_write, halted, instr_retired};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] cw(input int pcw, input int adr, input int memw, input int irw,
                                     input int rs, input int sa, input int sb, input int ac,
                                     input int rw, input int h, input int ret);
    return {15'd0, 1'(pcw), 1'(adr), 1'(memw), 1'(irw), 2'(rs), 2'(sa), 2'(sb), 3'(ac),
            1'(rw), 1'(h), 1'(ret)};
  endfunction

  task automatic cyc(input string tag, input logic [31:0] exp, input logic [31:0] mask);
    @(negedge clk);
    check(tag, 32'(obs) & mask, exp & mask);
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic note_retire();
    model_cnt = (model_cnt + 1) % (1 << CW);
    check("retire_count", 32'(retire_count), 32'(model_cnt));
  endtask

  task automatic do_reset(input int n);
    system_rst = 1'b1;
    mem_ready  = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("rst_enables", 32'({pc_write, mem_write, ir_write, reg_write, instr_retired, halted}), 32'd0);
      @(posedge clk);
      #1;
    end
    system_rst = 1'b0;
    model_cnt  = 0;
    check("rst_count", 32'(retire_count), 32'd0);
  endtask

  task automatic wait_state(input string tag, input int waits, input logic [31:0] busy,
                            input logic [31:0] done);
    int w = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
    for (int k = 0; k < w; k++) begin
      mem_ready = 1'b0;
      cyc(tag, busy, '1);
    end
    mem_ready = 1'b1;
    cyc(tag, done, '1);
  endtask

  task automatic halt_chk(input int n);
    repeat (n) begin
      mem_ready = 1'($urandom_range(0, 1));
      cyc("halt", cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), '1);
    end
    do_reset(1);
  endtask

  // Reference ALU decode: returns -1 for unsupported funct3
  function automatic int ref_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (o == T_R && f7) ? 1 : 0;
      3'd2:    return 5;
      3'd6:    return 3;
      3'd7:    return 2;
      default: return -1;
    endcase
  endfunction

  function automatic int ref_imm(input logic [6:0] o);
    if (o == T_SW)  return 1;
    if (o == T_BEQ) return 2;
    if (o == T_JAL) return 3;
    return 0;
  endfunction

  task automatic exec(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic z, input int waits);
    int  lat = 0;
    int  ac;
    logic halts = 1'b0;
    logic valid;
    logic [31:0] no_ac = ~cw(0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0);
    op = o; funct3 = f3; funct7b5 = f7; zero = z; ncyc = 0;
    wait_state("fetch", waits, cw(0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0), cw(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0));
    check("imm_src", 32'(imm_src), 32'(ref_imm(o)));
    mem_ready = (waits < 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc("decode", cw(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), '1);
    if (o == T_LW || o == T_SW) begin
      cyc("memadr", cw(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0), '1);
      if (o == T_LW) begin
        wait_state("memread", waits, cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("memwb", cw(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1), '1);
        lat = 5;
      end else begin
        wait_state("memwrite", waits, cw(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), cw(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        lat = 4;
      end
      note_retire();
    end else if (o == T_R || o == T_I) begin
      ac = ref_alu(o, f3, f7);
      if (ac < 0) begin
        cyc("exec_bad", cw(0, 0, 0, 0, 0, 2, (o == T_I) ? 1 : 0, 0, 0, 0, 0), no_ac);
        halts = 1'b1;
      end else begin
        cyc("exec", cw(0, 0, 0, 0, 0, 2, (o == T_I) ? 1 : 0, ac, 0, 0, 0), '1);
        cyc("aluwb", cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), '1);
        note_retire();
        lat = 4;
      end
    end else if (o == T_BEQ) begin
      valid = (f3 == 3'd0);
      cyc("beq", cw(int'(valid & z), 0, 0, 0, 0, 2, 0, 1, 0, 0, int'(valid)), '1);
      if (valid) begin
        note_retire();
        lat = 3;
      end else begin
        halts = 1'b1;
      end
    end else if (o == T_JAL) begin
      cyc("jal", cw(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0), '1);
      cyc("aluwb", cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), '1);
      note_retire();
      lat = 4;
    end else begin
      halts = 1'b1;
    end
    if (halts) halt_chk((waits == 0) ? 10 : 3);
    else if (waits == 0) check("latency", 32'(ncyc), 32'(lat));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] o;
    logic [2:0] f3;
    int sel;
    system_rst = 1'b1; op = T_LW; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);
    cyc("reset_fetch", cw(0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0), '1);

    // Earn one retire, then reset inside MEMWRITE while the write is still pending
    exec(T_I, 3'd0, 1'b0, 1'b0, 0);
    op = T_SW; funct3 = 3'd2;
    wait_state("fetch", 0, cw(0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0), cw(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0));
    cyc("decode", cw(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), '1);
    cyc("memadr", cw(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0), '1);
    mem_ready = 1'b0;
    cyc("memwrite_pre", cw(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), '1);
    do_reset(2);
    cyc("post_rst_fetch", cw(0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0), '1);
    do_reset(1);

    exec(T_LW, 3'd2, 1'b0, 1'b0, 0);
    exec(T_SW, 3'd2, 1'b0, 1'b0, 3);
    exec(T_R, 3'd0, 1'b1, 1'b0, 0);
    exec(T_I, 3'd0, 1'b1, 1'b0, 0);
    exec(T_BEQ, 3'd0, 1'b0, 1'b1, 0);
    exec(T_BEQ, 3'd0, 1'b0, 1'b0, 0);
    exec(T_JAL, 3'd5, 1'b1, 1'b1, 0);
    exec(T_R, 3'd7, 1'b0, 1'b0, 0);
    exec(T_R, 3'd4, 1'b0, 1'b0, 0);
    exec(7'b1111111, 3'd0, 1'b0, 1'b0, 0);
    exec(T_BEQ, 3'd1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 18; i++) exec(T_I, 3'd6, 1'b0, 1'b0, 0);

    for (int i = 0; i < 120; i++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: o = T_LW;
        1: o = T_SW;
        2: o = T_R;
        3, 7: o = T_I;
        4: o = T_BEQ;
        5: o = T_JAL;
        default: o = 7'($urandom);
      endcase
      if (o == T_BEQ) f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd0;
      else if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
      else begin
        sel = int'($urandom_range(0, 3));
        f3 = (sel == 0) ? 3'd0 : (sel == 1) ? 3'd2 : (sel == 2) ? 3'd6 : 3'd7;
      end
      exec(o, f3, 1'($urandom), 1'($urandom), ($urandom_range(0, 1) == 0) ? 0 : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
